// File: rtl/blink_pkg.sv
// Shared widths, default rates and state encodings for the LED blink-rate scheduler.
package blink_pkg;

    localparam int CNT_W = 27;

    localparam int unsigned      DEF_DEBOUNCE_CYC = 1_000_000;
    localparam logic [CNT_W-1:0] DEF_RATE0        = 27'd50_000_000;
    localparam logic [CNT_W-1:0] DEF_RATE1        = 27'd2_500_000;
    localparam logic [CNT_W-1:0] DEF_RATE2        = 27'd100_000_000;
    localparam logic [CNT_W-1:0] DEF_RATE3        = 27'd16_666_666;
    localparam int unsigned      DEF_AUTO_TOGGLES = 8;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } db_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } sched_state_t;

endpackage

// File: rtl/key_debounce.sv
// One push button: 2-flop synchroniser, debouncer, and press pulse on a debounced 1->0 edge.
//
//  state  | meaning
//  STABLE | synced level matches the debounced level
//  COUNT  | synced level differs; down-counting the cycles still required
module key_debounce
    import blink_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic key,
    output logic press
);

    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [1:0]      sync;
    logic            level, level_next;
    db_state_t       state, state_next;
    logic [DB_W-1:0] cnt, cnt_next;
    logic            differ, terminal;

    assign differ   = (sync[1] != level);
    // The cycle that enters COUNT is already the first differing cycle, so the
    // counter is loaded with the remaining count and terminates at 1.
    assign terminal = (state == STABLE) ? (DEBOUNCE_CYC <= 1) : (cnt == DB_W'(1));

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) sync <= 2'b11;
        else       sync <= {sync[0], key};
    end

    // Debouncer state, counter and accepted level.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state <= STABLE;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
        end
    end

    // Next-state logic; press fires in the cycle the new low level is accepted.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = level;
        press      = 1'b0;
        case (state)
            STABLE: begin
                if (differ) begin
                    if (terminal) begin
                        level_next = sync[1];
                        press      = ~sync[1];
                    end else begin
                        state_next = COUNT;
                        cnt_next   = DB_W'(DEBOUNCE_CYC - 1);
                    end
                end
            end
            COUNT: begin
                if (!differ) begin
                    state_next = STABLE;
                end else if (terminal) begin
                    state_next = STABLE;
                    level_next = sync[1];
                    press      = ~sync[1];
                end else begin
                    cnt_next = cnt - DB_W'(1);
                end
            end
            default: state_next = STABLE;
        endcase
    end

endmodule

// File: rtl/blink_rate_scheduler.sv
// LED blink-rate scheduler: four debounced keys select a half-period that is
// applied only at a half-period boundary. Optional feature macro: AUTO_CYCLE_EN
// (self-steps the rate every AUTO_TOGGLES boundaries when nothing is pending).
//
//  state | meaning
//  IDLE  | no rate change waiting
//  PEND  | pend_idx holds a rate to commit at the next boundary
module blink_rate_scheduler
    import blink_pkg::*;
#(
    parameter int unsigned      DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter logic [CNT_W-1:0] RATE0        = DEF_RATE0,
    parameter logic [CNT_W-1:0] RATE1        = DEF_RATE1,
    parameter logic [CNT_W-1:0] RATE2        = DEF_RATE2,
    parameter logic [CNT_W-1:0] RATE3        = DEF_RATE3,
    parameter int unsigned      AUTO_TOGGLES = DEF_AUTO_TOGGLES
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [3:0]       KEY,
    output logic [7:0]       LEDG,
    output logic [1:0]       rate_idx,
    output logic [CNT_W-1:0] period,
    output logic             pending
);

    logic [3:0]       press;
    logic             press_any;
    logic [1:0]       press_idx;
    logic [CNT_W-1:0] cnt;
    logic             boundary;
    sched_state_t     state, state_next;
    logic [1:0]       pend_idx, pend_next;
    logic             commit;
    logic [1:0]       commit_idx;
    logic [CNT_W-1:0] commit_rate;
    logic             auto_fire;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
            .CLOCK_50 (CLOCK_50),
            .RESET    (RESET),
            .key      (KEY[i]),
            .press    (press[i])
        );
    end

    assign press_any = |press;
    assign boundary  = (cnt >= period - CNT_W'(1));
    assign pending   = (state == PEND);

    // Lowest-index key wins when several presses land together.
    always_comb begin
        press_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (press[i]) press_idx = 2'(i);
        end
    end

`ifdef AUTO_CYCLE_EN
    localparam int TOG_W = $clog2(AUTO_TOGGLES + 1);
    logic [TOG_W-1:0] tog_cnt;

    assign auto_fire = boundary && (state == IDLE) && !press_any && (tog_cnt == TOG_W'(1));

    // Down-count boundaries without a pending request; reload on any press or self-step.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET)                      tog_cnt <= TOG_W'(AUTO_TOGGLES);
        else if (press_any || auto_fire) tog_cnt <= TOG_W'(AUTO_TOGGLES);
        else if (boundary && state == IDLE) tog_cnt <= tog_cnt - TOG_W'(1);
    end
`else
    logic unused_auto_toggles;
    assign unused_auto_toggles = (AUTO_TOGGLES != 0);
    assign auto_fire = 1'b0;
`endif

    // Scheduler next state; a press on a commit boundary becomes the next request.
    always_comb begin
        state_next = state;
        pend_next  = pend_idx;
        commit     = 1'b0;
        commit_idx = pend_idx;
        if (boundary && state == PEND) begin
            commit     = 1'b1;
            state_next = IDLE;
        end else if (auto_fire) begin
            commit     = 1'b1;
            commit_idx = rate_idx + 2'd1;
        end
        if (press_any) begin
            state_next = PEND;
            pend_next  = press_idx;
        end
    end

    // Rate lookup for the index being committed.
    always_comb begin
        case (commit_idx)
            2'd0:    commit_rate = RATE0;
            2'd1:    commit_rate = RATE1;
            2'd2:    commit_rate = RATE2;
            default: commit_rate = RATE3;
        endcase
    end

    // Scheduler registers and the rate in effect.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            pend_idx <= 2'd0;
            rate_idx <= 2'd0;
            period   <= RATE0;
        end else begin
            state    <= state_next;
            pend_idx <= pend_next;
            if (commit) begin
                rate_idx <= commit_idx;
                period   <= commit_rate;
            end
        end
    end

    // Half-period counter and LED toggle at each boundary.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            cnt  <= '0;
            LEDG <= 8'hFF;
        end else if (boundary) begin
            cnt  <= '0;
            LEDG <= ~LEDG;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule
